// File: rtl/sig_refine_bank.sv
// sig_refine_bank: per-channel synchroniser, glitch filter and edge detector
// for slow asynchronous inputs such as SPI/QPI sck and cs.
// Optional feature macro: SIG_REFINE_ACTIVITY_EN compiles in the per-channel
// activity stretcher that drives the activity outputs. Without it, activity
// is tied low and no stretch counters exist.
module sig_refine_bank #(
  parameter int unsigned         CHANNELS     = 4,
  parameter int unsigned         SYNC_STAGES  = 2,
  parameter int unsigned         FILTER_LEN   = 3,
  parameter logic [CHANNELS-1:0] RESET_LEVEL  = '0,
  parameter int unsigned         STRETCH_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] activity
);

  localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q;
  logic [CHANNELS-1:0][CNT_W-1:0]       cnt_d;
  logic [CHANNELS-1:0]                  accept;

  // Synchroniser shift chain; stage 0 captures the raw input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Agreement counter: restart whenever the sample matches the accepted level
  always_comb begin
    cnt_d  = '0;
    accept = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (s[i] != out[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Accepted level and single-cycle edge pulses, aligned with the new level
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out   <= RESET_LEVEL;
      rise  <= '0;
      fall  <= '0;
    end else begin
      cnt_q <= cnt_d;
      out   <= out ^ accept;
      rise  <= accept & s;
      fall  <= accept & ~s;
    end
  end

`ifdef SIG_REFINE_ACTIVITY_EN
  logic [CHANNELS-1:0][STRETCH_BITS-1:0] stretch_q;
  logic [CHANNELS-1:0][STRETCH_BITS-1:0] stretch_d;

  // Reload on every accepted edge, otherwise count down to zero
  always_comb begin
    stretch_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (accept[i]) begin
        stretch_d[i] = '1;
      end else if (stretch_q[i] != '0) begin
        stretch_d[i] = stretch_q[i] - STRETCH_BITS'(1);
      end
    end
  end

  // Activity is registered alongside the counter it reflects
  always_ff @(posedge clk) begin
    if (rst) begin
      stretch_q <= '0;
      activity  <= '0;
    end else begin
      stretch_q <= stretch_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        activity[i] <= (stretch_d[i] != '0);
      end
    end
  end
`else
  assign activity = '0;
`endif

endmodule

// File: doc/sig_refine_bank.md
SIG_REFINE_BANK -- requirements
Module: sig_refine_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels, range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flip-flops per channel, range 2..4.
REQ-003 SHALL have parameter FILTER_LEN, default 3: consecutive agreeing samples required to accept a new level, range 1..255.
REQ-004 SHALL have parameter RESET_LEVEL, default all zeros, CHANNELS bits wide: per-channel level loaded at reset.
REQ-005 SHALL have parameter STRETCH_BITS, default 20: width of the activity stretch counter.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port in, input, CHANNELS bits: asynchronous slow inputs (SPI/QPI sck, cs).
REQ-009 SHALL have port out, output, CHANNELS bits: filtered, glitch-free, clk-synchronous level.
REQ-010 SHALL have port rise, output, CHANNELS bits: one-cycle pulse when out goes 0->1.
REQ-011 SHALL have port fall, output, CHANNELS bits: one-cycle pulse when out goes 1->0.
REQ-012 SHALL have port activity, output, CHANNELS bits: stretched edge indicator for status LEDs.

Function
REQ-013 SHALL pass each in bit through SYNC_STAGES flip-flops; the last stage is the sample s.
REQ-014 SHALL keep a per-channel counter cnt, width ceil(log2(FILTER_LEN+1)), which SHALL clear to 0 in any cycle where s equals out.
REQ-015 SHALL increment cnt in each cycle where s differs from out and cnt < FILTER_LEN-1.
REQ-016 SHALL, on the clock edge where s differs from out and cnt == FILTER_LEN-1, set out to s and clear cnt.
REQ-017 SHALL give a total latency of exactly SYNC_STAGES+FILTER_LEN cycles from a stable input change (set up before an edge) to out changing.
REQ-018 SHALL ignore a pulse on in shorter than FILTER_LEN samples: out, rise and fall stay unchanged.
REQ-019 SHALL, when FILTER_LEN==1, accept every new sample on its first cycle, and out SHALL equal s delayed by one cycle.
REQ-020 SHALL assert rise or fall registered, high for exactly the one cycle in which out first shows its new value.
REQ-021 SHALL never assert rise and fall together on one channel.
REQ-022 SHALL process channels fully independently; simultaneous edges on several channels each produce their own pulse in the same cycle.
REQ-023 SHALL not saturate or wrap cnt beyond FILTER_LEN-1.

Reset
REQ-024 SHALL, while rst is high at a clock edge, load every synchroniser stage and out with RESET_LEVEL and clear cnt, rise, fall, the stretch counters and activity.
REQ-025 SHALL abort any in-progress filter count when reset is asserted mid-operation, with no edge pulse generated.
REQ-026 SHALL, after rst deasserts, treat an in level that differs from RESET_LEVEL as a normal change, with the REQ-017 latency.

Configuration
REQ-027 SHALL use macro SIG_REFINE_ACTIVITY_EN to compile in the activity stretcher.
REQ-028 SHALL, with SIG_REFINE_ACTIVITY_EN defined, load a per-channel STRETCH_BITS counter with all ones on each rise or fall.
REQ-029 SHALL, with SIG_REFINE_ACTIVITY_EN defined, decrement that counter to 0 otherwise, hold activity high while the counter is nonzero, and restart the count on each new edge.
REQ-030 SHALL, without SIG_REFINE_ACTIVITY_EN, tie activity to 0 and instantiate no stretch counters.

Verification
REQ-031 SHALL cover: CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=3, in[0] steps 0->1 -> out[0]=1 exactly 5 cycles later, rise[0] high for 1 cycle, fall[0]=0.
REQ-032 SHALL cover: in[1] high for 2 cycles, FILTER_LEN=3 -> out[1], rise[1] and fall[1] remain 0.
REQ-033 SHALL cover: in = 4'b1111 in one cycle -> rise = 4'b1111 in the same cycle, 5 cycles later.
REQ-034 SHALL cover: rst high for 1 cycle, 2 cycles after in[2] rises -> out[2] stays 0 and no rise[2] until 5 cycles after rst falls.
REQ-035 SHALL cover: FILTER_LEN=1 with an input toggling every 4 cycles -> out follows with a 3-cycle delay, alternating rise/fall pulses.
REQ-036 SHALL cover: SIG_REFINE_ACTIVITY_EN defined, STRETCH_BITS=4, one edge -> activity high for exactly 15 cycles; a second edge at cycle 10 extends it to cycle 25.
